// File: rtl/pc_fetch_pkg.sv
// Shared opcode-level constants for the PC/fetch stage and later branch logic:
// next-PC select codes, jump condition codes and status-register flag positions.
package pc_fetch_pkg;

    // Next-PC select driven by instr_dec; codes 4-7 behave as hold.
    localparam logic [2:0] MPC_HOLD = 3'd0;
    localparam logic [2:0] MPC_INC  = 3'd1;
    localparam logic [2:0] MPC_LOAD = 3'd2;
    localparam logic [2:0] MPC_JUMP = 3'd3;

    // Jump condition codes, instruction bits [12:10].
    localparam logic [2:0] JC_JNE = 3'd0;  // !Z
    localparam logic [2:0] JC_JEQ = 3'd1;  // Z
    localparam logic [2:0] JC_JNC = 3'd2;  // !C
    localparam logic [2:0] JC_JC  = 3'd3;  // C
    localparam logic [2:0] JC_JN  = 3'd4;  // N
    localparam logic [2:0] JC_JGE = 3'd5;  // !(N ^ V)
    localparam logic [2:0] JC_JL  = 3'd6;  // N ^ V
    localparam logic [2:0] JC_JMP = 3'd7;  // always

    // Bit positions inside the {V,N,Z,C} flag vector.
    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_N = 2;
    localparam int SR_V = 3;

endpackage

// File: rtl/pc_fetch_jump_cond_eval.sv
// Conditional-jump evaluator: decides whether a jump with condition code jcond
// is taken given the current {V,N,Z,C} status flags. Purely combinational.
module jump_cond_eval
    import pc_fetch_pkg::*;
(
    input  logic [2:0] jcond,
    input  logic [3:0] sr_flags,
    output logic       taken
);

    logic flag_v;
    logic flag_n;
    logic flag_z;
    logic flag_c;

    assign flag_v = sr_flags[SR_V];
    assign flag_n = sr_flags[SR_N];
    assign flag_z = sr_flags[SR_Z];
    assign flag_c = sr_flags[SR_C];

    // Map each condition code onto its flag test.
    always_comb begin
        // NOTE: default assignment first so no path leaves taken unassigned (no latch).
        taken = 1'b0;
        case (jcond)
            JC_JNE:  taken = ~flag_z;
            JC_JEQ:  taken = flag_z;
            JC_JNC:  taken = ~flag_c;
            JC_JC:   taken = flag_c;
            JC_JN:   taken = flag_n;
            JC_JGE:  taken = ~(flag_n ^ flag_v);
            JC_JL:   taken = flag_n ^ flag_v;
            JC_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter and fetch stage. Loads the initial PC from the reset vector,
// fetches the word at reg_PC_out over a req/ack ROM handshake, then applies
// instr_dec's next-PC select (hold / +2 / absolute load / conditional jump).
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = 16'hFFFE,
    parameter logic [15:0] PC_MASK   = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  MPC,
    input  logic [2:0]  jcond,
    input  logic [9:0]  joffset,
    input  logic [3:0]  SR_flags,
    input  logic [15:0] reg_Din,
    input  logic        rom_ack,
    input  logic [15:0] rom_rdata,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    output logic [15:0] reg_PC_out,
    output logic [15:0] MDB_out,
    output logic        fetch_valid
);

    localparam logic [1:0] ST_VEC_REQ = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    // Bit 0 of the PC is always cleared, whatever mask the integrator supplies.
    localparam logic [15:0] LOAD_MASK = PC_MASK & 16'hFFFE;

    logic [1:0]  state;
    logic        jump_taken;
    logic [15:0] pc_inc;
    logic [15:0] pc_jump;

    jump_cond_eval u_jump_cond_eval (
        .jcond    (jcond),
        .sr_flags (SR_flags),
        .taken    (jump_taken)
    );

    // Sequential successor and jump target. The 17-bit sum of PC+2 and the
    // sign-extended doubled offset is truncated to 16 bits, so computing it
    // directly in 16 bits gives the same wrapped result.
    assign pc_inc  = reg_PC_out + 16'd2;
    assign pc_jump = pc_inc + {{5{joffset[9]}}, joffset, 1'b0};

    // ROM request is a pure function of state and is dropped while rst is high;
    // address and request stay stable for as long as the ROM stalls.
    always_comb begin
        rom_req  = 1'b0;
        rom_addr = 16'h0000;
        if (!rst) begin
            case (state)
                ST_VEC_REQ: begin
                    rom_req  = 1'b1;
                    rom_addr = RESET_VEC;
                end
                ST_FETCH: begin
                    rom_req  = 1'b1;
                    rom_addr = reg_PC_out;
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM: vector load, word fetch, then next-PC selection in READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_VEC_REQ;
            reg_PC_out  <= 16'h0000;
            MDB_out     <= 16'h0000;
            fetch_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                ST_VEC_REQ: begin
                    if (rom_ack) begin
                        reg_PC_out <= rom_rdata & LOAD_MASK;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (rom_ack) begin
                        MDB_out     <= rom_rdata;
                        fetch_valid <= 1'b1;
                        state       <= ST_READY;
                    end
                end
                ST_READY: begin
                    case (MPC)
                        MPC_INC: begin
                            reg_PC_out  <= pc_inc & LOAD_MASK;
                            fetch_valid <= 1'b0;
                            state       <= ST_FETCH;
                        end
                        MPC_LOAD: begin
                            reg_PC_out  <= reg_Din & LOAD_MASK;
                            fetch_valid <= 1'b0;
                            state       <= ST_FETCH;
                        end
                        MPC_JUMP: begin
                            reg_PC_out  <= (jump_taken ? pc_jump : pc_inc) & LOAD_MASK;
                            fetch_valid <= 1'b0;
                            state       <= ST_FETCH;
                        end
                        MPC_HOLD: ;
                        default:  ;
                    endcase
                end
                default: state <= ST_VEC_REQ;
            endcase
        end
    end

endmodule
